// File: rtl/histogram_align_accumulator.sv
// Histogram align/accumulate stage: rebuilds the weighted sum of each signed
// per-bit-weight histogram (bin k carries weight 2^k), BINS_PER_CYCLE bins per
// cycle, folds it into a running signed partial sum and emits that sum after
// the histogram flagged as last.
module histogram_align_accumulator #(
    parameter int NUM_BINS       = 16,
    parameter int BIN_W          = 6,
    parameter int BINS_PER_CYCLE = 4,
    parameter int ACC_W          = 32
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [NUM_BINS*BIN_W-1:0] BeforeAllignmentVector,
    input  logic                      InLast,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [ACC_W-1:0]          OutPartialSum,
    output logic                      OutOverflow
);

    localparam int NUM_SLICES = NUM_BINS / BINS_PER_CYCLE;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        EMIT
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [NUM_BINS*BIN_W-1:0] vec_q;
    logic                      last_q;
    logic [CNT_W-1:0]          slice_q;
    logic [ACC_W-1:0]          acc_q;
    logic                      ovf_q;
    logic                      live_q;   // low until the first clock after reset

    logic [ACC_W-1:0]          slice_sum;
    logic [ACC_W-1:0]          acc_sum;
    logic                      add_ovf;
    logic [BIN_W-1:0]          bin_v;
    logic [ACC_W-1:0]          term_v;
    int                        bin_idx;
    logic                      accept;
    logic                      emit_done;
    logic                      slice_end;

    // Sign-extend, align and sum the bins of the current slice at full ACC_W width.
    always_comb begin
        // NOTE: every variable gets a default before any loop/branch so no latch is inferred.
        slice_sum = '0;
        bin_v     = '0;
        term_v    = '0;
        bin_idx   = 0;
        for (int j = 0; j < BINS_PER_CYCLE; j++) begin
            bin_idx   = int'(slice_q) * BINS_PER_CYCLE + j;
            bin_v     = vec_q[bin_idx*BIN_W +: BIN_W];
            term_v    = {{(ACC_W-BIN_W){bin_v[BIN_W-1]}}, bin_v} << bin_idx;
            slice_sum = slice_sum + term_v;
        end
        acc_sum = acc_q + slice_sum;
        // Signed overflow: operands agree in sign, result disagrees.
        add_ovf = (acc_q[ACC_W-1] == slice_sum[ACC_W-1]) &&
                  (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake/result outputs.
    always_comb begin
        state_d       = state_q;
        InReady       = 1'b0;
        OutValid      = 1'b0;
        OutPartialSum = '0;
        OutOverflow   = 1'b0;
        slice_end     = (slice_q == LAST_SLICE);
        case (state_q)
            IDLE: begin
                InReady = live_q;
                if (InValid && live_q) state_d = ALIGN;
            end
            ALIGN: begin
                if (slice_end) state_d = last_q ? EMIT : IDLE;
            end
            EMIT: begin
                OutValid      = 1'b1;
                OutPartialSum = acc_q;
                OutOverflow   = ovf_q;
                if (OutReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept    = InValid && InReady;
        emit_done = OutValid && OutReady;
    end

    // Capture, slice accumulation and group clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            // NOTE: the captured vector is cleared too, so a stale histogram can never leak after reset.
            vec_q   <= '0;
            last_q  <= 1'b0;
            slice_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                vec_q   <= BeforeAllignmentVector;
                last_q  <= InLast;
                slice_q <= '0;
            end else if (state_q == ALIGN) begin
                acc_q   <= acc_sum;
                ovf_q   <= ovf_q | add_ovf;
                slice_q <= slice_q + CNT_W'(1);
            end else if (emit_done) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_histogram_align_accumulator.sv
// Directed self-checking bench for histogram_align_accumulator. A second
// instance with ACC_W=16 shares all inputs to exercise wrap and overflow.
module tb_histogram_align_accumulator;

    localparam int NB = 16;
    localparam int BW = 6;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            InValid;
    logic            InReady, InReady16;
    logic [NB*BW-1:0] vec;
    logic            InLast;
    logic            OutValid, OutValid16;
    logic            OutReady;
    logic [31:0]     OutPartialSum;
    logic [15:0]     OutPartialSum16;
    logic            OutOverflow, OutOverflow16;

    int passed = 0;
    int total  = 0;
    int n;
    logic [NB*BW-1:0] v;
    logic             stable;

    always #5 Clk = ~Clk;

    histogram_align_accumulator dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .BeforeAllignmentVector(vec), .InLast(InLast), .OutValid(OutValid),
        .OutReady(OutReady), .OutPartialSum(OutPartialSum), .OutOverflow(OutOverflow)
    );

    histogram_align_accumulator #(.ACC_W(16)) dut16 (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady16),
        .BeforeAllignmentVector(vec), .InLast(InLast), .OutValid(OutValid16),
        .OutReady(OutReady), .OutPartialSum(OutPartialSum16), .OutOverflow(OutOverflow16)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [NB*BW-1:0] set_bin(input logic [NB*BW-1:0] base,
                                                 input int k, input int val);
        logic [NB*BW-1:0] r;
        r = base;
        r[k*BW +: BW] = BW'(val);
        return r;
    endfunction

    // Present a histogram and return at the negedge right after the accepting edge.
    task automatic send(input logic [NB*BW-1:0] hv, input logic last);
        int w;
        w = 0;
        @(negedge Clk);
        InValid = 1'b1;
        vec     = hv;
        InLast  = last;
        while (!InReady && w < 50) begin
            @(negedge Clk);
            w++;
        end
        if (w >= 50) check("send_timeout", 0, 1);
        @(posedge Clk);
        @(negedge Clk);
        InValid = 1'b0;
    endtask

    // Count edges after acceptance until a result appears or the block is ready again.
    task automatic run_align(output int edges);
        edges = 0;
        while (!(OutValid || InReady) && edges < 50) begin
            @(negedge Clk);
            edges++;
        end
    endtask

    task automatic take_out();
        OutReady = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        OutReady = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; InValid = 1'b0; vec = '0; InLast = 1'b0; OutReady = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_in_ready", InReady, 0);
        check("rst_out_valid", OutValid, 0);
        check("rst_sum", OutPartialSum, 0);
        check("rst_ovf", OutOverflow, 0);
        Reset = 1'b0;
        @(negedge Clk);
        check("ready_after_rst", InReady, 1);

        // Single bin0=+1 group: latency and value.
        send(set_bin('0, 0, 1), 1'b1);
        run_align(n);
        check("lat_bin0", n, 4);
        check("valid_bin0", OutValid, 1);
        check("sum_bin0", $signed(OutPartialSum), 1);
        check("ovf_bin0", OutOverflow, 0);
        take_out();
        check("valid_after_take", OutValid, 0);

        // Extreme-weight negative bin plus a small positive one.
        v = set_bin(set_bin('0, 15, -16), 3, 5);
        send(v, 1'b1);
        run_align(n);
        check("sum_neg", $signed(OutPartialSum), -524248);
        take_out();

        // Three all-ones histograms in one group.
        v = '0;
        for (int k = 0; k < NB; k++) v = set_bin(v, k, 1);
        send(v, 1'b0);
        run_align(n);
        check("g1_align_len", n, 4);
        check("g1_no_valid", OutValid, 0);
        send(v, 1'b0);
        run_align(n);
        check("g2_align_len", n, 4);
        check("g2_no_valid", OutValid, 0);
        send(v, 1'b1);
        run_align(n);
        check("g3_align_len", n, 4);
        check("sum_ones", $signed(OutPartialSum), 196605);
        take_out();

        // Backpressure in EMIT; pending input is refused until IDLE.
        send(set_bin('0, 2, 3), 1'b1);
        run_align(n);
        check("bp_valid", OutValid, 1);
        @(negedge Clk);
        InValid = 1'b1;
        vec     = set_bin('0, 0, 1);
        InLast  = 1'b1;
        stable  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (!(OutValid === 1'b1 && $signed(OutPartialSum) === 32'sd12 && InReady === 1'b0))
                stable = 1'b0;
            @(negedge Clk);
        end
        check("bp_stable", stable, 1);
        OutReady = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        OutReady = 1'b0;
        check("bp_released", OutValid, 0);
        check("bp_idle_ready", InReady, 1);
        @(posedge Clk);
        @(negedge Clk);
        InValid = 1'b0;
        run_align(n);
        check("bp_next_lat", n, 4);
        check("bp_next_sum", $signed(OutPartialSum), 1);
        take_out();

        // Wrap and overflow in the 16-bit instance.
        v = set_bin(set_bin('0, 14, 1), 13, 1);
        send(v, 1'b0);
        run_align(n);
        send(v, 1'b1);
        run_align(n);
        check("w16_valid", OutValid16, 1);
        check("w16_sum", $signed(OutPartialSum16), -16384);
        check("w16_ovf", OutOverflow16, 1);
        check("w32_sum", $signed(OutPartialSum), 49152);
        check("w32_ovf", OutOverflow, 0);
        take_out();
        send(set_bin('0, 0, 1), 1'b1);
        run_align(n);
        check("w16_next_sum", $signed(OutPartialSum16), 1);
        check("w16_next_ovf", OutOverflow16, 0);
        take_out();

        // Reset in the second ALIGN cycle discards the group.
        send(set_bin('0, 5, 7), 1'b1);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("mid_rst_valid", OutValid, 0);
        check("mid_rst_ready", InReady, 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("post_rst_ready", InReady, 1);
        check("post_rst_valid", OutValid, 0);
        send(set_bin('0, 1, 2), 1'b1);
        run_align(n);
        check("post_rst_lat", n, 4);
        check("post_rst_sum", $signed(OutPartialSum), 4);
        check("post_rst_ovf", OutOverflow, 0);
        take_out();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/histogram_align_accumulator.md
Name: histogram_align_accumulator

Overview:
- Consumes the per-bit-weight signed histograms produced by the PE histogram stage, one 16-bin vector per handshake.
- Reconstructs the weighted sum of each histogram: bin k carries weight 2^k.
- Accumulates successive histograms into one signed partial sum, which it emits when the histogram flagged as last has been folded in.
- Sits between the histogram stage and the PE output/partial-sum path. It processes BINS_PER_CYCLE bins per cycle to bound adder width.

Parameters:
- NUM_BINS, 16, number of histogram bins (bit weights 0..NUM_BINS-1); must be a multiple of BINS_PER_CYCLE.
- BIN_W, 6, width of each signed bin count (two's complement).
- BINS_PER_CYCLE, 4, bins aligned and summed per ALIGN cycle.
- ACC_W, 32, signed accumulator and output width.

Ports:
- Clk  input  1  clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  histogram presented.
- InReady  output  1  block can accept a histogram.
- BeforeAllignmentVector  input  NUM_BINS x BIN_W  signed count per bit weight; element k has weight 2^k.
- InLast  input  1  this histogram closes the accumulation group; sampled with the handshake.
- OutValid  output  1  OutPartialSum is valid.
- OutReady  input  1  downstream accepts the result.
- OutPartialSum  output  ACC_W  signed accumulated sum.
- OutOverflow  output  1  sticky: signed overflow occurred in the current group; valid with OutValid.

Behaviour:
- Reset is asynchronous and active-high. While Reset is high:
  - FSM goes to IDLE.
  - Accumulator, captured vector, captured last flag, slice counter and overflow flag are all cleared to 0.
  - InReady=0, OutValid=0, OutPartialSum=0, OutOverflow=0.
  - InReady goes to 1 on the first clock after Reset deasserts; the block is in IDLE.
- FSM has three states: IDLE, ALIGN, EMIT.
- IDLE:
  - InReady=1.
  - On a rising edge with InValid&InReady: capture BeforeAllignmentVector and InLast, clear the slice counter, go to ALIGN.
  - Input is ignored when InValid=0.
- ALIGN:
  - InReady=0.
  - Each cycle, slice s (bins s*BINS_PER_CYCLE .. s*BINS_PER_CYCLE+BINS_PER_CYCLE-1) is processed:
    - each bin is sign-extended from BIN_W to ACC_W and shifted left by its bin index;
    - the bin terms are summed and added into the accumulator; the slice counter increments.
  - After slice NUM_BINS/BINS_PER_CYCLE-1: go to EMIT if the captured last flag is 1, else go to IDLE. The accumulator is retained when returning to IDLE.
  - With defaults, ALIGN lasts 4 cycles.
- EMIT:
  - InReady=0, OutValid=1, OutPartialSum=accumulator, OutOverflow=sticky flag. These are held stable while OutReady=0.
  - On OutValid&OutReady: clear the accumulator and overflow flag, go to IDLE.
- Latency: handshake accepted at edge T gives OutValid=1 after edge T+NUM_BINS/BINS_PER_CYCLE (T+4 with defaults). Throughput is one histogram per 1+NUM_BINS/BINS_PER_CYCLE cycles.
- Arithmetic:
  - All adds are two's complement and wrap modulo 2^ACC_W.
  - OutOverflow is set if any accumulator add produces signed overflow (both operands the same sign, result of the opposite sign). It stays set until the emit handshake.
  - The slice sum itself is computed at ACC_W width.
  - Bin values span the full BIN_W range (-32..+31 with defaults); no clamping.
- Boundary conditions:
  - An all-zero histogram still takes the full ALIGN time.
  - A group of one histogram (InLast=1 on the first input) is legal.
  - InValid held high during ALIGN or EMIT is not accepted; upstream must hold its data.
  - No input is accepted in the same cycle as the EMIT handshake. The next acceptance is possible one cycle later, in IDLE.
  - Reset asserted mid-ALIGN or mid-EMIT discards the partial sum and the pending result immediately.

Test Plan:
- Reset release, then bin0=+1, all others 0, InLast=1 -> OutValid rises exactly 4 cycles after acceptance; OutPartialSum=1, OutOverflow=0.
- bin15=-16, bin3=+5, all others 0, InLast=1 -> OutPartialSum = -16*32768 + 40 = -524248.
- Three histograms with all bins=+1; InLast=0, 0, 1 -> OutValid only after the third; OutPartialSum = 3*65535 = 196605. InReady is 0 during every ALIGN.
- OutReady held 0 for 5 cycles in EMIT -> OutValid and OutPartialSum stay stable; InValid=1 is not accepted; the handshake on the 6th cycle clears the accumulator, and the next group result starts from 0.
- ACC_W=16, two histograms each with bin14=+1, bin13=+1 (24576 each) -> sum wraps to -16384; OutOverflow=1. The next group, with bin0=+1, gives 1 with OutOverflow=0.
- Reset pulse during the 2nd ALIGN cycle of a group -> OutValid=0, InReady=1 one cycle after release; a following single histogram with bin1=+2 yields 4.
